// File: rtl/pio_pulse_pkg.sv
// Shared definitions for the pio_pulse_sequencer codebase slice.
// Holds the command opcodes, the sequencer FSM states and the bit positions
// used in the pio_0 command word and the pio_1 status word.
package pio_pulse_pkg;

    // Command opcodes carried in cmd_word[14:12]; 6 and 7 are illegal.
    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_LOAD_DELAY = 3'd1,
        OP_LOAD_WIDTH = 3'd2,
        OP_ARM        = 3'd3,
        OP_ABORT      = 3'd4,
        OP_CLR_ERR    = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        HIGH  = 2'd3
    } state_e;

    // Status word bit positions; bits 3:0 carry pulses_done[3:0].
    localparam int unsigned ST_ACK   = 7;
    localparam int unsigned ST_ARMED = 6;
    localparam int unsigned ST_RUN   = 5;
    localparam int unsigned ST_ERR   = 4;

    // Command word toggle strobe position.
    localparam int unsigned CMD_TOGGLE = 15;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// An input edge produces a single-cycle rise_o pulse three clocks later.
//
// Ports:
//   clk    - destination clock
//   reset  - asynchronous, active-high reset; all flops clear to 0
//   d_i    - asynchronous input level
//   rise_o - one-cycle pulse on a synchronised rising edge of d_i
module sync_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;
    logic rise_d;

    assign rise_d = sync2_q & ~prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/pio_pulse_sequencer.sv
// Triggered delay/width pulse sequencer driven by the HPS through pio_0 and
// reporting back through pio_1.
//
// Ports:
//   clk         - fabric clock (clk_clk domain)
//   reset       - asynchronous, active-high reset
//   cmd_word    - [15] toggle strobe, [14:12] opcode, [11:0] operand
//   trig_in     - asynchronous external trigger
//   status_word - [7] ack toggle, [6] armed, [5] running, [4] err,
//                 [3:0] pulses_done[3:0]
//   pulse_out   - registered timing pulse
module pio_pulse_sequencer
    import pio_pulse_pkg::*;
#(
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cmd_word,
    input  logic        trig_in,
    output logic [7:0]  status_word,
    output logic        pulse_out
);

    localparam logic [7:0]       PreMax = 8'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       count_q, count_d;
    logic [7:0]       pulses_done_q, pulses_done_d;
    logic [7:0]       presc_q, presc_d;
    logic             toggle_q, toggle_d;
    logic             err_q, err_d;
    logic             soft_trig_q, soft_trig_d;
    logic             pulse_q, pulse_d;

    logic             trig_rise;
    logic             cmd_accept;
    logic [2:0]       opcode;
    logic [CNT_W-1:0] operand;
    logic             abort;
    logic             trig;
    logic             tick;
    logic [7:0]       done_inc;

    sync_edge_det u_trig_sync (
        .clk    (clk),
        .reset  (reset),
        .d_i    (trig_in),
        .rise_o (trig_rise)
    );

    assign cmd_accept = cmd_word[CMD_TOGGLE] != toggle_q;
    assign opcode     = cmd_word[14:12];
    assign operand    = cmd_word[CNT_W-1:0];
    assign trig       = trig_rise | soft_trig_q;
    assign tick       = presc_q == PreMax;
    assign done_inc   = (pulses_done_q == 8'hFF) ? 8'hFF : pulses_done_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        delay_d       = delay_q;
        width_d       = width_q;
        cnt_d         = cnt_q;
        count_d       = count_q;
        pulses_done_d = pulses_done_q;
        toggle_d      = toggle_q;
        err_d         = err_q;
        soft_trig_d   = 1'b0;
        abort         = 1'b0;
        presc_d       = tick ? 8'd0 : presc_q + 8'd1;

        // Commands are decoded before the FSM so ABORT can pre-empt a trigger.
        if (cmd_accept) begin
            toggle_d = cmd_word[CMD_TOGGLE];
            case (opcode)
                OP_NOP: ;
                OP_LOAD_DELAY: begin
                    if (state_q == IDLE) delay_d = operand;
                    else                 err_d   = 1'b1;
                end
                OP_LOAD_WIDTH: begin
                    if (state_q == IDLE) width_d = (operand == '0) ? CntOne : operand;
                    else                 err_d   = 1'b1;
                end
                OP_ARM: begin
                    if (state_q == IDLE) begin
                        state_d       = ARMED;
                        count_d       = operand[7:0];
                        pulses_done_d = 8'd0;
                        soft_trig_d   = operand[8];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_ABORT:   abort = 1'b1;
                OP_CLR_ERR: err_d = 1'b0;
                default:    err_d = 1'b1;
            endcase
        end

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            presc_d = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: ;
                ARMED: begin
                    if (trig) begin
                        // Restart the prescaler so timing is locked to the trigger.
                        presc_d = 8'd0;
                        if (delay_q == '0) begin
                            state_d = HIGH;
                            cnt_d   = width_q - CntOne;
                        end else begin
                            state_d = DELAY;
                            cnt_d   = delay_q - CntOne;
                        end
                    end
                end
                DELAY: begin
                    if (tick) begin
                        if (cnt_q == '0) begin
                            state_d = HIGH;
                            cnt_d   = width_q - CntOne;
                        end else begin
                            cnt_d = cnt_q - CntOne;
                        end
                    end
                end
                HIGH: begin
                    if (tick) begin
                        if (cnt_q == '0) begin
                            cnt_d         = '0;
                            pulses_done_d = done_inc;
                            // count_q of zero means run forever.
                            if ((count_q != 8'd0) && (done_inc >= count_q)) state_d = IDLE;
                            else                                            state_d = ARMED;
                        end else begin
                            cnt_d = cnt_q - CntOne;
                        end
                    end
                end
            endcase
        end

        pulse_d = state_d == HIGH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            delay_q       <= '0;
            width_q       <= CntOne;
            cnt_q         <= '0;
            count_q       <= 8'd0;
            pulses_done_q <= 8'd0;
            presc_q       <= 8'd0;
            toggle_q      <= 1'b0;
            err_q         <= 1'b0;
            soft_trig_q   <= 1'b0;
            pulse_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            delay_q       <= delay_d;
            width_q       <= width_d;
            cnt_q         <= cnt_d;
            count_q       <= count_d;
            pulses_done_q <= pulses_done_d;
            presc_q       <= presc_d;
            toggle_q      <= toggle_d;
            err_q         <= err_d;
            soft_trig_q   <= soft_trig_d;
            pulse_q       <= pulse_d;
        end
    end

    // The ack bit is the last-seen toggle, which lags cmd_word[15] by one clock.
    always_comb begin
        status_word           = 8'd0;
        status_word[ST_ACK]   = toggle_q;
        status_word[ST_ARMED] = state_q == ARMED;
        status_word[ST_RUN]   = (state_q == DELAY) || (state_q == HIGH);
        status_word[ST_ERR]   = err_q;
        status_word[3:0]      = pulses_done_q[3:0];
    end

    assign pulse_out = pulse_q;

endmodule

// File: tb/tb_pio_pulse_sequencer.sv
// Bench for pio_pulse_sequencer: one instance with PRESCALE=1 and one with
// PRESCALE=4. Expected pulses (rise cycle, width) are queued when stimulus is
// driven and checked by per-instance monitors when each pulse ends.
module tb_pio_pulse_sequencer;

    localparam logic [2:0] OpNop   = 3'd0;
    localparam logic [2:0] OpLoadD = 3'd1;
    localparam logic [2:0] OpLoadW = 3'd2;
    localparam logic [2:0] OpArm   = 3'd3;
    localparam logic [2:0] OpAbort = 3'd4;
    localparam logic [2:0] OpClrE  = 3'd5;
    localparam logic [2:0] OpBad   = 3'd7;

    typedef struct {
        int rise;
        int width;
    } pulse_exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] cmd1, cmd4;
    logic        trig1, trig4;
    logic [7:0]  st1, st4;
    logic        p1, p4;
    logic        tog1, tog4;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    pulse_exp_t q1[$];
    pulse_exp_t q4[$];

    pio_pulse_sequencer #(.CNT_W(12), .PRESCALE(1)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_word    (cmd1),
        .trig_in     (trig1),
        .status_word (st1),
        .pulse_out   (p1)
    );

    pio_pulse_sequencer #(.CNT_W(12), .PRESCALE(4)) u_dut4 (
        .clk         (clk),
        .reset       (reset),
        .cmd_word    (cmd4),
        .trig_in     (trig4),
        .status_word (st4),
        .pulse_out   (p4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitors: compare each completed pulse against the queue head.
    bit         m1_prev = 1'b0;
    int         m1_rise = 0;
    pulse_exp_t m1_e;
    initial forever begin
        @(negedge clk);
        if (p1 && !m1_prev) m1_rise = cyc;
        if (!p1 && m1_prev) begin
            n_cmp++;
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL pulse1_unexpected: rise=%0d width=%0d, none expected",
                         m1_rise, cyc - m1_rise);
            end else begin
                m1_e = q1.pop_front();
                if (m1_rise !== m1_e.rise || (cyc - m1_rise) !== m1_e.width) begin
                    n_fail++;
                    $display("FAIL pulse1: rise=%0d width=%0d, want rise=%0d width=%0d",
                             m1_rise, cyc - m1_rise, m1_e.rise, m1_e.width);
                end
            end
        end
        m1_prev = p1;
    end

    bit         m4_prev = 1'b0;
    int         m4_rise = 0;
    pulse_exp_t m4_e;
    initial forever begin
        @(negedge clk);
        if (p4 && !m4_prev) m4_rise = cyc;
        if (!p4 && m4_prev) begin
            n_cmp++;
            if (q4.size() == 0) begin
                n_fail++;
                $display("FAIL pulse4_unexpected: rise=%0d width=%0d, none expected",
                         m4_rise, cyc - m4_rise);
            end else begin
                m4_e = q4.pop_front();
                if (m4_rise !== m4_e.rise || (cyc - m4_rise) !== m4_e.width) begin
                    n_fail++;
                    $display("FAIL pulse4: rise=%0d width=%0d, want rise=%0d width=%0d",
                             m4_rise, cyc - m4_rise, m4_e.rise, m4_e.width);
                end
            end
        end
        m4_prev = p4;
    end

    // Drives a command at the current negedge; returns one negedge later.
    task automatic send_cmd(input int which, input logic [2:0] op, input logic [11:0] operand,
                            output int dc);
        dc = cyc;
        if (which == 1) begin
            tog1 = ~tog1;
            cmd1 = {tog1, op, operand};
        end else begin
            tog4 = ~tog4;
            cmd4 = {tog4, op, operand};
        end
        @(negedge clk);
    endtask

    task automatic push_exp(input int which, input int rise, input int width);
        pulse_exp_t e;
        e.rise  = rise;
        e.width = width;
        if (which == 1) q1.push_back(e);
        else            q4.push_back(e);
    endtask

    task automatic wait_drain(input int which, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (((which == 1) ? q1.size() : q4.size()) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cmd1  = 16'h0;
        cmd4  = 16'h0;
        trig1 = 1'b0;
        trig4 = 1'b0;
        tog1  = 1'b0;
        tog4  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (st1 !== 8'h00) begin n_fail++; $display("FAIL reset_st1: got %h want 00", st1); end
        n_cmp++;
        if (p1 !== 1'b0) begin n_fail++; $display("FAIL reset_p1: got %b want 0", p1); end
        n_cmp++;
        if (st4 !== 8'h00) begin n_fail++; $display("FAIL reset_st4: got %h want 00", st4); end
        n_cmp++;
        if (p4 !== 1'b0) begin n_fail++; $display("FAIL reset_p4: got %b want 0", p4); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_post_reset_ack();
        int dc;
        send_cmd(1, OpNop, 12'h000, dc);
        n_cmp++;
        if (st1 !== 8'h80) begin n_fail++; $display("FAIL first_ack: got %h want 80", st1); end
        n_cmp++;
        if (p1 !== 1'b0) begin n_fail++; $display("FAIL first_ack_pulse: got %b want 0", p1); end
    endtask

    task automatic test_basic_timing();
        int dc;
        int n;
        bit ok;
        send_cmd(1, OpLoadD, 12'd5, dc);
        n_cmp++;
        if (st1 !== {tog1, 7'b000_0000}) begin
            n_fail++; $display("FAIL load_delay_ack: got %h want %h", st1, {tog1, 7'b0});
        end
        send_cmd(1, OpLoadW, 12'd3, dc);
        send_cmd(1, OpArm, 12'd1, dc);
        n_cmp++;
        if (st1 !== {tog1, 7'b100_0000}) begin
            n_fail++; $display("FAIL arm_status: got %h want %h", st1, {tog1, 7'b100_0000});
        end
        n = cyc;
        trig1 = 1'b1;
        push_exp(1, n + 9, 3);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (st1[6:5] !== 2'b01) begin
            n_fail++; $display("FAIL delay_running: got %b want 01", st1[6:5]);
        end
        trig1 = 1'b0;
        wait_drain(1, 40, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL basic_pulse_timeout: got none want 1 pulse"); end
        n_cmp++;
        if (st1 !== {tog1, 7'b000_0001}) begin
            n_fail++; $display("FAIL basic_done: got %h want %h", st1, {tog1, 7'b000_0001});
        end
    endtask

    task automatic test_sw_burst();
        int dc;
        int n;
        bit ok;
        send_cmd(4, OpLoadD, 12'd0, dc);
        send_cmd(4, OpLoadW, 12'd2, dc);
        send_cmd(4, OpArm, 12'h103, dc);
        push_exp(4, dc + 2, 8);
        n_cmp++;
        if (st4 !== {tog4, 7'b100_0000}) begin
            n_fail++; $display("FAIL burst_arm: got %h want %h", st4, {tog4, 7'b100_0000});
        end
        wait_drain(4, 40, ok);
        n_cmp++;
        if (!ok || st4 !== {tog4, 7'b100_0001}) begin
            n_fail++; $display("FAIL burst_sw: got %h want %h", st4, {tog4, 7'b100_0001});
        end
        for (int k = 2; k <= 3; k++) begin
            n = cyc;
            trig4 = 1'b1;
            push_exp(4, n + 4, 8);
            repeat (4) @(negedge clk);
            trig4 = 1'b0;
            wait_drain(4, 40, ok);
            n_cmp++;
            if (!ok) begin n_fail++; $display("FAIL burst_timeout: pulse %0d missing", k); end
        end
        n_cmp++;
        if (st4 !== {tog4, 7'b000_0011}) begin
            n_fail++; $display("FAIL burst_done: got %h want %h", st4, {tog4, 7'b000_0011});
        end
    endtask

    task automatic test_error();
        int dc;
        int n;
        bit ok;
        send_cmd(1, OpArm, 12'd0, dc);
        n_cmp++;
        if (st1 !== {tog1, 7'b100_0000}) begin
            n_fail++; $display("FAIL err_arm: got %h want %h", st1, {tog1, 7'b100_0000});
        end
        send_cmd(1, OpLoadW, 12'd7, dc);
        n_cmp++;
        if (st1 !== {tog1, 7'b101_0000}) begin
            n_fail++; $display("FAIL err_load_armed: got %h want %h", st1, {tog1, 7'b101_0000});
        end
        // Width must still be 3 despite the rejected load.
        n = cyc;
        trig1 = 1'b1;
        push_exp(1, n + 9, 3);
        repeat (4) @(negedge clk);
        trig1 = 1'b0;
        wait_drain(1, 40, ok);
        n_cmp++;
        if (!ok || st1 !== {tog1, 7'b101_0001}) begin
            n_fail++; $display("FAIL err_rearm: got %h want %h", st1, {tog1, 7'b101_0001});
        end
        send_cmd(1, OpAbort, 12'd0, dc);
        n_cmp++;
        if (st1 !== {tog1, 7'b001_0001}) begin
            n_fail++; $display("FAIL err_sticky: got %h want %h", st1, {tog1, 7'b001_0001});
        end
        send_cmd(1, OpClrE, 12'd0, dc);
        n_cmp++;
        if (st1 !== {tog1, 7'b000_0001}) begin
            n_fail++; $display("FAIL err_clr1: got %h want %h", st1, {tog1, 7'b000_0001});
        end
        send_cmd(1, OpBad, 12'hFFF, dc);
        n_cmp++;
        if (st1 !== {tog1, 7'b001_0001}) begin
            n_fail++; $display("FAIL err_illegal: got %h want %h", st1, {tog1, 7'b001_0001});
        end
        send_cmd(1, OpClrE, 12'd0, dc);
        n_cmp++;
        if (st1 !== {tog1, 7'b000_0001}) begin
            n_fail++; $display("FAIL err_clr2: got %h want %h", st1, {tog1, 7'b000_0001});
        end
    endtask

    task automatic test_abort();
        int dc;
        int n;
        send_cmd(1, OpLoadD, 12'd0, dc);
        send_cmd(1, OpLoadW, 12'd10, dc);
        send_cmd(1, OpArm, 12'd1, dc);
        n = cyc;
        trig1 = 1'b1;
        push_exp(1, n + 4, 3);
        repeat (6) @(negedge clk);
        n_cmp++;
        if (p1 !== 1'b1) begin n_fail++; $display("FAIL abort_pre_high: got %b want 1", p1); end
        send_cmd(1, OpAbort, 12'd0, dc);
        n_cmp++;
        if (p1 !== 1'b0) begin n_fail++; $display("FAIL abort_pulse_low: got %b want 0", p1); end
        n_cmp++;
        if (st1[7:4] !== {tog1, 3'b000}) begin
            n_fail++; $display("FAIL abort_idle: got %h want %h", st1[7:4], {tog1, 3'b000});
        end
        trig1 = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (q1.size() !== 0) begin
            n_fail++; $display("FAIL abort_truncated: got %0d pending want 0", q1.size());
        end
        trig1 = 1'b1;
        repeat (20) @(negedge clk);
        trig1 = 1'b0;
        n_cmp++;
        if (st1[6:5] !== 2'b00) begin
            n_fail++; $display("FAIL abort_ignore_trig: got %b want 00", st1[6:5]);
        end
    endtask

    task automatic test_collision_reset();
        int dc;
        int n;
        bit saw_high;
        bit ok;
        send_cmd(1, OpArm, 12'd1, dc);
        trig1 = 1'b1;
        repeat (3) @(negedge clk);
        // ABORT lands on the same edge the trigger detect is consumed.
        send_cmd(1, OpAbort, 12'd0, dc);
        saw_high = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (p1) saw_high = 1'b1;
            @(negedge clk);
        end
        trig1 = 1'b0;
        n_cmp++;
        if (saw_high !== 1'b0) begin
            n_fail++; $display("FAIL collision_pulse: got %b want 0", saw_high);
        end
        n_cmp++;
        if (st1[6:5] !== 2'b00) begin
            n_fail++; $display("FAIL collision_state: got %b want 00", st1[6:5]);
        end

        send_cmd(1, OpLoadD, 12'd20, dc);
        send_cmd(1, OpArm, 12'd1, dc);
        repeat (2) @(negedge clk);
        n = cyc;
        trig1 = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++;
        if (st1[6:5] !== 2'b01) begin
            n_fail++; $display("FAIL mid_delay: got %b want 01 (trig at %0d)", st1[6:5], n);
        end
        reset = 1'b1;
        cmd1  = 16'h0;
        cmd4  = 16'h0;
        trig1 = 1'b0;
        #1;
        n_cmp++;
        if (st1 !== 8'h00 || p1 !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got st=%h p=%b want 00/0", st1, p1);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tog1  = 1'b0;
        tog4  = 1'b0;
        @(negedge clk);
        send_cmd(1, OpNop, 12'd0, dc);
        n_cmp++;
        if (st1 !== 8'h80) begin n_fail++; $display("FAIL post_reset_ack: got %h want 80", st1); end
        // Reset values: delay 0, width 1.
        send_cmd(1, OpArm, 12'h101, dc);
        push_exp(1, dc + 2, 1);
        wait_drain(1, 20, ok);
        n_cmp++;
        if (!ok || st1 !== {tog1, 7'b000_0001}) begin
            n_fail++; $display("FAIL reset_defaults: got %h want %h", st1, {tog1, 7'b000_0001});
        end
    endtask

    initial begin
        test_reset();
        test_post_reset_ack();
        test_basic_timing();
        test_sw_burst();
        test_error();
        test_abort();
        test_collision_reset();
        repeat (5) @(negedge clk);
        n_cmp++;
        if (q1.size() !== 0 || q4.size() !== 0) begin
            n_fail++;
            $display("FAIL pending_pulses: got %0d/%0d want 0/0", q1.size(), q4.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
